// File: rtl/writeback_arbiter.sv
// Completion-side tracker: follows each functional unit from issue to completion
// and round-robin arbitrates finished units onto the single writeback port.
module writeback_arbiter #(
    parameter int REG_ADDR_SIZE     = 4,
    parameter int PRED_ADDR_SIZE    = 2,
    parameter int FUNC_UNIT_OP_SIZE = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_FUNC_UNITS    = 1 << FUNC_UNIT_OP_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 issue,
    input  logic [FUNC_UNIT_OP_SIZE-1:0]         func_unit,
    input  logic [REG_ADDR_SIZE-1:0]             reg_dest_addr,
    input  logic                                 reg_dest_valid,
    input  logic [PRED_ADDR_SIZE-1:0]            pred_dest_addr,
    input  logic                                 pred_dest_valid,
    input  logic [NUM_FUNC_UNITS-1:0]            unit_done,
    input  logic [NUM_FUNC_UNITS*DATA_WIDTH-1:0] unit_reg_result,
    input  logic [NUM_FUNC_UNITS-1:0]            unit_pred_result,
    output logic [NUM_FUNC_UNITS-1:0]            free_units,
    output logic                                 wr_reg,
    output logic [REG_ADDR_SIZE-1:0]             wr_reg_addr,
    output logic [DATA_WIDTH-1:0]                wr_reg_data,
    output logic                                 wr_pred,
    output logic [PRED_ADDR_SIZE-1:0]            wr_pred_addr,
    output logic                                 wr_pred_data,
    output logic [FUNC_UNIT_OP_SIZE-1:0]         wb_unit_id,
    output logic                                 issue_err
);

    localparam int UNIT_W = FUNC_UNIT_OP_SIZE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_WB = 2'd2
    } unit_state_t;

    unit_state_t                state      [NUM_FUNC_UNITS];
    unit_state_t                state_next [NUM_FUNC_UNITS];

    logic [REG_ADDR_SIZE-1:0]   cap_reg_addr  [NUM_FUNC_UNITS];
    logic                       cap_reg_valid [NUM_FUNC_UNITS];
    logic [PRED_ADDR_SIZE-1:0]  cap_pred_addr [NUM_FUNC_UNITS];
    logic                       cap_pred_valid[NUM_FUNC_UNITS];
    logic [DATA_WIDTH-1:0]      cap_reg_data  [NUM_FUNC_UNITS];
    logic                       cap_pred_data [NUM_FUNC_UNITS];

    logic [UNIT_W-1:0]          rr_ptr;
    logic [UNIT_W-1:0]          cand;
    logic [UNIT_W-1:0]          grant_id;
    logic                       grant_valid;

    // First WAIT_WB unit at or after rr_ptr; the UNIT_W-bit add wraps for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_FUNC_UNITS; k++) begin
            cand = rr_ptr + UNIT_W'(k);
            if (!grant_valid && state[cand] == WAIT_WB) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_FUNC_UNITS; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE: begin
                    if (issue && func_unit == UNIT_W'(i))
                        state_next[i] = EXEC;
                end
                EXEC: begin
                    if (unit_done[i])
                        state_next[i] = (cap_reg_valid[i] || cap_pred_valid[i]) ? WAIT_WB : IDLE;
                end
                WAIT_WB: begin
                    if (grant_valid && grant_id == UNIT_W'(i))
                        state_next[i] = IDLE;
                end
                default: state_next[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FUNC_UNITS; i++) begin
            if (reset)
                state[i] <= IDLE;
            else
                state[i] <= state_next[i];
        end
    end

    always_comb begin
        free_units = '0;
        for (int unsigned i = 0; i < NUM_FUNC_UNITS; i++)
            free_units[i] = (state[i] == IDLE);
    end

    // Dest tags latch at issue, results latch at completion.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FUNC_UNITS; i++) begin
            if (reset) begin
                cap_reg_addr[i]   <= '0;
                cap_reg_valid[i]  <= 1'b0;
                cap_pred_addr[i]  <= '0;
                cap_pred_valid[i] <= 1'b0;
                cap_reg_data[i]   <= '0;
                cap_pred_data[i]  <= 1'b0;
            end else begin
                if (state[i] == IDLE && issue && func_unit == UNIT_W'(i)) begin
                    cap_reg_addr[i]   <= reg_dest_addr;
                    cap_reg_valid[i]  <= reg_dest_valid;
                    cap_pred_addr[i]  <= pred_dest_addr;
                    cap_pred_valid[i] <= pred_dest_valid;
                end
                if (state[i] == EXEC && unit_done[i]) begin
                    cap_reg_data[i]  <= unit_reg_result[i*DATA_WIDTH +: DATA_WIDTH];
                    cap_pred_data[i] <= unit_pred_result[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_err <= 1'b0;
        end else if (issue && state[func_unit] != IDLE) begin
            issue_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            wr_reg       <= 1'b0;
            wr_pred      <= 1'b0;
            wr_reg_addr  <= '0;
            wr_reg_data  <= '0;
            wr_pred_addr <= '0;
            wr_pred_data <= 1'b0;
            wb_unit_id   <= '0;
        end else begin
            wr_reg  <= grant_valid && cap_reg_valid[grant_id];
            wr_pred <= grant_valid && cap_pred_valid[grant_id];
            if (grant_valid) begin
                rr_ptr       <= grant_id + 1'b1;
                wr_reg_addr  <= cap_reg_addr[grant_id];
                wr_reg_data  <= cap_reg_data[grant_id];
                wr_pred_addr <= cap_pred_addr[grant_id];
                wr_pred_data <= cap_pred_data[grant_id];
                wb_unit_id   <= grant_id;
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Completion-side counterpart to the decode-stage scoreboard.
- Tracks each functional unit from issue to completion and arbitrates finished units onto the single writeback port.
- Drives wr_reg/wr_reg_addr and wr_pred/wr_pred_addr, which clear scoreboard busy bits, and free_units, which gates issue.
- Sits between the functional units and the register/predicate files.

Parameters:
REG_ADDR_SIZE, 4, register address width
PRED_ADDR_SIZE, 2, predicate address width
FUNC_UNIT_OP_SIZE, 3, unit id width; NUM_FUNC_UNITS = 1 << FUNC_UNIT_OP_SIZE
DATA_WIDTH, 32, register result width

Ports:
clk  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-high
issue  in  1  instruction issued this cycle
func_unit  in  FUNC_UNIT_OP_SIZE  target unit of issued instruction
reg_dest_addr  in  REG_ADDR_SIZE  register dest of issued instruction
reg_dest_valid  in  1  issued instruction writes a register
pred_dest_addr  in  PRED_ADDR_SIZE  predicate dest of issued instruction
pred_dest_valid  in  1  issued instruction writes a predicate
unit_done  in  NUM_FUNC_UNITS  one-cycle completion pulse per unit
unit_reg_result  in  NUM_FUNC_UNITS*DATA_WIDTH  unit i result in bits [i*DATA_WIDTH +: DATA_WIDTH]; sampled at unit_done
unit_pred_result  in  NUM_FUNC_UNITS  predicate result per unit; sampled at unit_done
free_units  out  NUM_FUNC_UNITS  bit i = unit i IDLE
wr_reg  out  1  register writeback strobe
wr_reg_addr  out  REG_ADDR_SIZE  register writeback address
wr_reg_data  out  DATA_WIDTH  register writeback data
wr_pred  out  1  predicate writeback strobe
wr_pred_addr  out  PRED_ADDR_SIZE  predicate writeback address
wr_pred_data  out  1  predicate writeback value
wb_unit_id  out  FUNC_UNIT_OP_SIZE  unit granted the current writeback
issue_err  out  1  sticky: issue targeted a non-IDLE unit

Behaviour:
- Per-unit FSM with states IDLE, EXEC, WAIT_WB. Each unit also holds captured dest tags (addr and valid for reg and pred) and captured results.
- IDLE -> EXEC: on issue with func_unit==i. Capture reg/pred dest addr and valid bits.
- EXEC -> WAIT_WB: on unit_done[i]. Capture unit_reg_result slice and unit_pred_result[i].
- EXEC -> IDLE: on unit_done[i] when both captured valids are 0 (no writeback needed). No grant is consumed.
- WAIT_WB -> IDLE: on the cycle unit i is granted.
- unit_done[i] in IDLE or WAIT_WB is ignored.
- Issue to a unit in EXEC or WAIT_WB: ignored, unit state unchanged, issue_err set to 1. issue_err stays 1 until reset.
- free_units[i] = (state_i == IDLE). Decoded from registered state; no combinational path from inputs.
- Arbitration:
  - Round-robin over units in WAIT_WB, one grant per cycle.
  - Search starts at rr_ptr. After a grant to unit g, rr_ptr = g+1, wrapping modulo NUM_FUNC_UNITS.
  - rr_ptr is unchanged when there is no grant.
- Writeback outputs are registered and asserted the cycle after the grant:
  - wr_reg = granted reg valid; wr_pred = granted pred valid.
  - addr/data/wb_unit_id come from the granted unit.
  - With no grant, wr_reg = wr_pred = 0; addr/data/id hold their last values.
  - One instruction may assert wr_reg and wr_pred together.
- Latency: unit_done at cycle N -> WAIT_WB at N+1 -> earliest grant at N+1 -> wr_* strobe and free_units[i]=1 at N+2. Earliest re-issue to that unit is at N+2.
- Issue and grant to different units in the same cycle are independent.
- Reset: all units IDLE, free_units all 1s, rr_ptr 0, wr_reg=0, wr_pred=0, all addr/data/wb_unit_id 0, issue_err 0.
  - Reset mid-operation discards all in-flight and pending writebacks.
  - Issue and unit_done are ignored during reset.

Test Plan:
- Reset, then issue to unit 1 with reg_dest_addr=5, reg_dest_valid=1, then unit_done[1] at cycle N with result 0xDEADBEEF -> at N+2: wr_reg=1, wr_reg_addr=5, wr_reg_data=0xDEADBEEF, wb_unit_id=1, free_units[1]=1. free_units[1]=0 from the cycle after issue until N+2.
- Units 0, 2, 5 pending, each with a distinct reg dest; unit_done pulsed for all three in one cycle, rr_ptr=0 -> writebacks from units 0, 2, 5 on three consecutive cycles, one wr_reg per cycle.
- Issue to unit 3 with pred_dest_addr=2, pred_dest_valid=1 and reg_dest_valid=0; done with pred result 1 -> wr_pred=1, wr_pred_addr=2, wr_pred_data=1, wr_reg=0.
- Issue with no valid dests (store) to unit 4, then done -> no wr strobe; free_units[4]=1 on the cycle after done.
- Issue to unit 2 while it is in EXEC -> issue_err=1 and stays 1. The original dest is still written back on completion.
- Assert reset while 3 units are in WAIT_WB -> cycle after reset: free_units=8'hFF, no wr strobes, issue_err=0.
